// File: rtl/twi_slave_core.sv
// Two-wire target responder: oversampled SCL/SDA, 7-bit address match, ACK, RX/TX byte paths.
// Optional TWI_SLAVE_GCALL_EN also accepts the general-call write address (8'h00).
`timescale 1ns/1ps
module twi_slave_core #(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter logic [7:0] CR_ADDR  = 8'h10,
    parameter logic [7:0] TD_ADDR  = 8'h11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic [7:0] wr_addr,
    input  logic [7:0] data_in,
    input  logic       twi_scl_i,
    input  logic       twi_sda_i,
    output logic       twi_sda_oen,
    output logic [7:0] i2sr,
    output logic [7:0] i2srd
);

    // state    | meaning
    // IDLE     | bus free or not addressed, waiting for START
    // ADDR     | shifting in the address byte
    // ADDR_ACK | address matched, driving ACK on the 9th clock
    // RX       | shifting in a write data byte
    // RX_ACK   | driving ACK/NACK for the received byte
    // TX       | shifting out a read data byte
    // TX_ACK   | sampling master ACK/NACK
    // WAIT     | not ours or master NACKed; released until START/STOP
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT
    } state_t;

    logic   r_scl_s1, r_scl_s2, r_scl_d;
    logic   r_sda_s1, r_sda_s2, r_sda_d;
    state_t r_state, w_state;
    logic [2:0] r_bit_cnt, w_bit_cnt;
    logic       r_done, w_done;
    logic [7:0] r_shift, w_shift;
    logic       r_oen, w_oen;
    logic       r_en, w_en;
    logic       r_nack, w_nack;
    logic       r_rw, w_rw;
    logic       r_addr_hit, w_addr_hit;
    logic       r_rx_valid, w_rx_valid;
    logic       r_tx_req, w_tx_req;
    logic       r_nack_rcvd, w_nack_rcvd;
    logic       r_stop_seen, w_stop_seen;
    logic [7:0] r_rx_data, w_rx_data;
    logic [7:0] r_tx_reg, w_tx_reg;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_match;
    logic [7:0] w_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Idle-high reset values keep the first sampled cycle from looking like an edge.
            {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
        end else begin
            r_scl_s1 <= twi_scl_i;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= twi_sda_i;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_byte     = {r_shift[6:0], r_sda_s2};

`ifdef TWI_SLAVE_GCALL_EN
    assign w_match = (w_byte[7:1] == SLV_ADDR) || (w_byte == 8'h00);
`else
    assign w_match = (w_byte[7:1] == SLV_ADDR);
`endif

    always_comb begin
        w_state     = r_state;
        w_bit_cnt   = r_bit_cnt;
        w_done      = r_done;
        w_shift     = r_shift;
        w_oen       = r_oen;
        w_en        = r_en;
        w_nack      = r_nack;
        w_rw        = r_rw;
        w_addr_hit  = r_addr_hit;
        w_rx_valid  = r_rx_valid;
        w_tx_req    = r_tx_req;
        w_nack_rcvd = r_nack_rcvd;
        w_stop_seen = r_stop_seen;
        w_rx_data   = r_rx_data;
        w_tx_reg    = r_tx_reg;

        // Host clears are applied first so a same-cycle hardware set wins.
        if (wr && wr_addr == CR_ADDR) begin
            w_en   = data_in[0];
            w_nack = data_in[1];
            if (data_in[2]) begin
                w_rx_valid  = 1'b0;
                w_nack_rcvd = 1'b0;
                w_stop_seen = 1'b0;
            end
        end

        if (!r_en) begin
            w_state   = S_IDLE;
            w_oen     = 1'b1;
            w_bit_cnt = 3'd0;
            w_done    = 1'b0;
        end else if (w_stop) begin
            w_state   = S_IDLE;
            w_oen     = 1'b1;
            w_bit_cnt = 3'd0;
            w_done    = 1'b0;
            if (r_addr_hit)
                w_stop_seen = 1'b1;
        end else if (w_start) begin
            w_state    = S_ADDR;
            w_oen      = 1'b1;
            w_bit_cnt  = 3'd0;
            w_done     = 1'b0;
            w_addr_hit = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: w_oen = 1'b1;
                S_ADDR: if (w_scl_rise) begin
                    w_shift = w_byte;
                    if (r_bit_cnt == 3'd7) begin
                        w_bit_cnt = 3'd0;
                        if (w_match) begin
                            w_addr_hit = 1'b1;
                            w_rw       = w_byte[0];
                            w_state    = S_ADDR_ACK;
                        end else begin
                            w_state = S_WAIT;
                        end
                    end else begin
                        w_bit_cnt = r_bit_cnt + 3'd1;
                    end
                end
                S_ADDR_ACK: if (w_scl_fall) begin
                    if (!r_done) begin
                        w_oen  = 1'b0;
                        w_done = 1'b1;
                    end else begin
                        w_done    = 1'b0;
                        w_bit_cnt = 3'd0;
                        if (!r_rw) begin
                            w_oen   = 1'b1;
                            w_state = S_RX;
                        end else begin
                            w_shift  = r_tx_reg;
                            w_tx_req = 1'b1;
                            w_oen    = r_tx_reg[7];
                            w_state  = S_TX;
                        end
                    end
                end
                S_RX: if (w_scl_rise) begin
                    w_shift = w_byte;
                    if (r_bit_cnt == 3'd7) begin
                        w_rx_data  = w_byte;
                        w_rx_valid = 1'b1;
                        w_bit_cnt  = 3'd0;
                        w_done     = 1'b0;
                        w_state    = S_RX_ACK;
                    end else begin
                        w_bit_cnt = r_bit_cnt + 3'd1;
                    end
                end
                S_RX_ACK: if (w_scl_fall) begin
                    if (!r_done) begin
                        w_oen  = r_nack;
                        w_done = 1'b1;
                    end else begin
                        w_oen   = 1'b1;
                        w_done  = 1'b0;
                        w_state = S_RX;
                    end
                end
                S_TX: if (w_scl_fall) begin
                    // r_done marks a reloaded byte whose MSB is still to be driven.
                    if (r_done) begin
                        w_oen  = r_shift[7];
                        w_done = 1'b0;
                    end else if (r_bit_cnt == 3'd7) begin
                        w_oen     = 1'b1;
                        w_bit_cnt = 3'd0;
                        w_state   = S_TX_ACK;
                    end else begin
                        w_oen     = r_shift[6];
                        w_shift   = {r_shift[6:0], 1'b0};
                        w_bit_cnt = r_bit_cnt + 3'd1;
                    end
                end
                S_TX_ACK: if (w_scl_rise) begin
                    w_bit_cnt = 3'd0;
                    if (!r_sda_s2) begin
                        w_shift  = r_tx_reg;
                        w_tx_req = 1'b1;
                        w_done   = 1'b1;
                        w_state  = S_TX;
                    end else begin
                        w_nack_rcvd = 1'b1;
                        w_state     = S_WAIT;
                    end
                end
                S_WAIT: w_oen = 1'b1;
                default: begin
                    w_state = S_IDLE;
                    w_oen   = 1'b1;
                end
            endcase
        end

        // A TD write on the cycle the shifter loads: shifter already took the old value.
        if (wr && wr_addr == TD_ADDR) begin
            w_tx_reg = data_in;
            w_tx_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_done      <= 1'b0;
            r_shift     <= 8'h00;
            r_oen       <= 1'b1;
            r_en        <= 1'b0;
            r_nack      <= 1'b0;
            r_rw        <= 1'b0;
            r_addr_hit  <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_tx_req    <= 1'b0;
            r_nack_rcvd <= 1'b0;
            r_stop_seen <= 1'b0;
            r_rx_data   <= 8'h00;
            r_tx_reg    <= 8'hFF;
        end else begin
            r_state     <= w_state;
            r_bit_cnt   <= w_bit_cnt;
            r_done      <= w_done;
            r_shift     <= w_shift;
            r_oen       <= w_oen;
            r_en        <= w_en;
            r_nack      <= w_nack;
            r_rw        <= w_rw;
            r_addr_hit  <= w_addr_hit;
            r_rx_valid  <= w_rx_valid;
            r_tx_req    <= w_tx_req;
            r_nack_rcvd <= w_nack_rcvd;
            r_stop_seen <= w_stop_seen;
            r_rx_data   <= w_rx_data;
            r_tx_reg    <= w_tx_reg;
        end
    end

    assign twi_sda_oen = r_oen;
    assign i2srd       = r_rx_data;
    assign i2sr        = {(r_state != S_IDLE), r_rw, r_addr_hit, r_rx_valid,
                          r_tx_req, r_nack_rcvd, r_stop_seen, r_en};

endmodule

// File: tb/tb_twi_slave_core.sv
// Bench for twi_slave_core: bit-level bus master, open-drain SDA, transaction-level reference model.
`timescale 1ns/1ps
module tb_twi_slave_core;
    localparam logic [6:0] SLV = 7'h50;
    localparam logic [7:0] CR  = 8'h10;
    localparam logic [7:0] TD  = 8'h11;
    localparam int Q = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       twi_sda_oen;
    logic [7:0] i2sr, i2srd;
    wire        sda_bus = sda_m & twi_sda_oen;

    always #5 clk = ~clk;

    twi_slave_core #(.SLV_ADDR(SLV), .CR_ADDR(CR), .TD_ADDR(TD)) dut (
        .clk(clk), .rst(rst), .wr(wr), .wr_addr(wr_addr), .data_in(data_in),
        .twi_scl_i(scl_m), .twi_sda_i(sda_bus),
        .twi_sda_oen(twi_sda_oen), .i2sr(i2sr), .i2srd(i2srd)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: status as the specification's rules define it after each transaction
    bit m_en, m_nack, m_rw, m_hit, m_rxv, m_txr, m_nrx, m_stop;
    logic [7:0] m_rd, m_tx;
    logic [7:0] payload [4];

    function automatic bit m_match(input logic [7:0] b);
`ifdef TWI_SLAVE_GCALL_EN
        return (b[7:1] == SLV) || (b == 8'h00);
`else
        return (b[7:1] == SLV);
`endif
    endfunction

    function automatic logic [7:0] m_status();
        return {1'b0, m_rw, m_hit, m_rxv, m_txr, m_nrx, m_stop, m_en};
    endfunction

    task automatic m_reset();
        {m_en, m_nack, m_rw, m_hit, m_rxv, m_txr, m_nrx, m_stop} = '0;
        m_rd = 8'h00;
        m_tx = 8'hFF;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        wr = 1'b1; wr_addr = a; data_in = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic cr_wr(input logic [7:0] d);
        host_wr(CR, d);
        m_en = d[0];
        m_nack = d[1];
        if (d[2]) begin m_rxv = 0; m_nrx = 0; m_stop = 0; end
    endtask

    task automatic td_wr(input logic [7:0] d);
        host_wr(TD, d);
        m_tx = d;
        m_txr = 0;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
        m_hit = 0;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
        if (m_hit) m_stop = 1;
    endtask

    task automatic bus_bit(input logic b, output logic r);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        r = sda_bus;  wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
        bus_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic m_ack, output logic [7:0] d, output logic ninth);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, r);
            d[i] = r;
        end
        bus_bit(m_ack ? 1'b0 : 1'b1, ninth);
    endtask

    task automatic end_checks();
        chk("i2srd", {24'h0, i2srd}, {24'h0, m_rd});
        chk("i2sr", {24'h0, i2sr}, {24'h0, m_status()});
    endtask

    task automatic do_write(input logic [7:0] abyte, input int n);
        logic a;
        bit hit;
        hit = m_match(abyte) && !abyte[0];
        bus_start();
        send_byte(abyte, a);
        chk("addr_ack", {31'h0, a}, {31'h0, !hit});
        if (hit) begin m_hit = 1; m_rw = 0; end
        for (int i = 0; i < n; i++) begin
            send_byte(payload[i], a);
            if (hit) begin
                chk("wdata_ack", {31'h0, a}, {31'h0, m_nack});
                m_rd = payload[i];
                m_rxv = 1;
            end else begin
                chk("wdata_noack", {31'h0, a}, 32'h1);
            end
        end
        bus_stop();
        end_checks();
    endtask

    task automatic do_read(input logic [7:0] abyte, input int n);
        logic a, ninth;
        logic [7:0] d;
        bit hit;
        hit = m_match(abyte) && abyte[0];
        bus_start();
        send_byte(abyte, a);
        chk("raddr_ack", {31'h0, a}, {31'h0, !hit});
        if (hit) begin m_hit = 1; m_rw = 1; m_txr = 1; end
        for (int i = 0; i < n; i++) begin
            recv_byte(i < n - 1, d, ninth);
            chk("rd_byte", {24'h0, d}, {24'h0, hit ? m_tx : 8'hFF});
            if (i == n - 1) begin
                chk("rd_ninth_released", {31'h0, ninth}, 32'h1);
                if (hit) m_nrx = 1;
            end
        end
        bus_stop();
        end_checks();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a, ninth, r;
        logic [7:0] d, prev_rd;
        m_reset();
        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);
        chk("rst_oen", {31'h0, twi_sda_oen}, 32'h1);
        chk("rst_i2sr", {24'h0, i2sr}, 32'h0);
        chk("rst_i2srd", {24'h0, i2srd}, 32'h0);

        // write transfer
        cr_wr(8'h01);
        payload[0] = 8'h3C;
        do_write(8'hA0, 1);
        chk("wr_i2sr_literal", {24'h0, i2sr}, 32'h33);

        // address mismatch
        cr_wr(8'h05);
        payload[0] = 8'h55;
        do_write(8'hA2, 1);
        chk("mis_hit_rxv", {30'h0, i2sr[5], i2sr[4]}, 32'h0);

        // read transfer
        td_wr(8'h96);
        do_read(8'hA1, 1);
        chk("rd_busy", {31'h0, i2sr[7]}, 32'h0);

        // repeated start after 4 data bits
        cr_wr(8'h05);
        bus_start();
        send_byte(8'hA0, a);
        chk("rs_addr_ack", {31'h0, a}, 32'h0);
        m_hit = 1; m_rw = 0;
        for (int i = 0; i < 4; i++) bus_bit(1'($urandom_range(0, 1)), r);
        bus_start();
        send_byte(8'hA1, a);
        chk("rs_raddr_ack", {31'h0, a}, 32'h0);
        m_hit = 1; m_rw = 1; m_txr = 1;
        recv_byte(1'b0, d, ninth);
        chk("rs_rd_byte", {24'h0, d}, {24'h0, m_tx});
        m_nrx = 1;
        bus_stop();
        end_checks();
        chk("rs_rxv", {31'h0, i2sr[4]}, 32'h0);

        // reset while ACKing the address
        bus_start();
        for (int i = 7; i >= 0; i--) begin
            d = 8'hA0;
            bus_bit(d[i], r);
        end
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        chk("rst_pre_ack", {31'h0, sda_bus}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_oen", {31'h0, twi_sda_oen}, 32'h1);
        chk("rst_mid_i2sr", {24'h0, i2sr}, 32'h0);
        chk("rst_mid_i2srd", {24'h0, i2srd}, 32'h0);
        rst = 1'b0;
        m_reset();
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
        bus_stop();
        cr_wr(8'h01);
        payload[0] = 8'h3C;
        do_write(8'hA0, 1);
        do_read(8'hA1, 1);

        // general call
        prev_rd = m_rd;
        payload[0] = 8'h12;
        do_write(8'h00, 1);
`ifdef TWI_SLAVE_GCALL_EN
        chk("gcall_rd", {24'h0, i2srd}, 32'h12);
`else
        chk("gcall_rd", {24'h0, i2srd}, {24'h0, prev_rd});
`endif

        // randomized transactions
        for (int t = 0; t < 14; t++) begin
            logic [7:0] abyte;
            int n;
            cr_wr({5'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1});
            if ($urandom_range(0, 1)) td_wr(8'($urandom));
            abyte[7:1] = $urandom_range(0, 2) != 0 ? SLV : 7'($urandom);
            abyte[0]   = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) payload[i] = 8'($urandom);
            if (abyte[0]) do_read(abyte, n);
            else          do_write(abyte, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
